// File: rtl/fp32_align_ctrl.sv
// fp32_align_ctrl: exponent-alignment sequencer for the fp32 adder.
// On an accepted start it latches both operands and picks the one with the
// smaller exponent. That operand is loaded into the external temp register and
// shifted right |exp_a - exp_b| times, with the count saturated at MAX_SHIFT.
// Optional feature macro: FP32_ALIGN_STICKY_EN enables the sticky bit, which
// accumulates the bits shifted out of temp. With the macro undefined, sticky
// is tied to 0.
module fp32_align_ctrl #(
   parameter int MAX_SHIFT = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  exp_a,
   input  logic [7:0]  exp_b,
   input  logic [22:0] man_a,
   input  logic [22:0] man_b,
   input  logic        temp_lsb,
   output logic        ldt,
   output logic        shr,
   output logic [22:0] inp_temp,
   output logic [22:0] man_big,
   output logic [7:0]  exp_res,
   output logic        swap,
   output logic [4:0]  shift_cnt,
   output logic        busy,
   output logic        done,
   output logic        sticky
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam logic [8:0] MAX9 = 9'(MAX_SHIFT);

   state_t      state, state_nxt;
   logic        a_lt_b;
   logic        accept;
   logic [8:0]  diff;
   logic [4:0]  cnt_cap;

   // Saturate on the full 9-bit difference so large gaps never wrap in 5 bits.
   assign a_lt_b  = (exp_a < exp_b);
   assign diff    = a_lt_b ? ({1'b0, exp_b} - {1'b0, exp_a})
                           : ({1'b0, exp_a} - {1'b0, exp_b});
   assign cnt_cap = (diff > MAX9) ? 5'(MAX_SHIFT) : diff[4:0];
   assign accept  = (state == IDLE) && start;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and Moore strobes
   always_comb begin
      state_nxt = state;
      ldt       = 1'b0;
      shr       = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            ldt       = 1'b1;
            state_nxt = (shift_cnt != 5'd0) ? SHIFT : DONE;
         end
         SHIFT: begin
            shr = 1'b1;
            if (shift_cnt <= 5'd1) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture on the accepting edge; values hold until the next accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         swap     <= 1'b0;
         exp_res  <= 8'd0;
         inp_temp <= 23'd0;
         man_big  <= 23'd0;
      end else if (accept) begin
         swap     <= a_lt_b;
         exp_res  <= a_lt_b ? exp_b : exp_a;
         inp_temp <= a_lt_b ? man_a : man_b;
         man_big  <= a_lt_b ? man_b : man_a;
      end
   end

   // Remaining-shift counter: loaded on accept, one decrement per SHIFT cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                shift_cnt <= 5'd0;
      else if (accept)          shift_cnt <= cnt_cap;
      else if (state == SHIFT)  shift_cnt <= shift_cnt - 5'd1;
   end

`ifdef FP32_ALIGN_STICKY_EN
   // Sticky: cleared at load, then ORs in each bit about to leave temp
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               sticky <= 1'b0;
      else if (state == LOAD)  sticky <= 1'b0;
      else if (state == SHIFT) sticky <= sticky | temp_lsb;
   end
`else
   logic unused_temp_lsb;
   assign unused_temp_lsb = temp_lsb;
   assign sticky          = 1'b0;
`endif

endmodule

// File: tb/tb_fp32_align_ctrl.sv
// Directed bench for fp32_align_ctrl with a behavioural 24-bit temp register.
module tb_fp32_align_ctrl;

   logic        clk = 1'b0;
   bit          clk_en = 1'b0;
   logic        reset, start, temp_lsb;
   logic [7:0]  exp_a, exp_b, exp_res;
   logic [22:0] man_a, man_b, inp_temp, man_big;
   logic        ldt, shr, swap, busy, done, sticky;
   logic [4:0]  shift_cnt;
   logic [23:0] temp;
   int          total = 0;
   int          bad = 0;

   always #5 if (clk_en) clk = ~clk;

   fp32_align_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
      .temp_lsb(temp_lsb), .ldt(ldt), .shr(shr), .inp_temp(inp_temp),
      .man_big(man_big), .exp_res(exp_res), .swap(swap),
      .shift_cnt(shift_cnt), .busy(busy), .done(done), .sticky(sticky)
   );

   // Temp register model: load with hidden bit, shift right on shr
   always @(posedge clk) begin
      if (ldt)      temp <= {1'b1, inp_temp};
      else if (shr) temp <= temp >> 1;
   end
   assign temp_lsb = temp[0];

   // One request: start held for one edge, then profile cycles 1..40
   task automatic run_op(input logic [7:0] ea, input logic [7:0] eb,
                         input logic [22:0] ma, input logic [22:0] mb,
                         output int n_ldt, output int n_shr, output int ldt_cyc,
                         output int done_cyc, output logic [4:0] cnt_load,
                         output logic both, output logic stk);
      n_ldt = 0; n_shr = 0; ldt_cyc = 0; done_cyc = 0;
      cnt_load = 5'h1F; both = 1'b0; stk = 1'bx;
      @(negedge clk);
      exp_a = ea; exp_b = eb; man_a = ma; man_b = mb; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         if (ldt) begin n_ldt++; ldt_cyc = c; cnt_load = shift_cnt; end
         if (shr) n_shr++;
         if (ldt && shr) both = 1'b1;
         if (done) begin done_cyc = c; stk = sticky; break; end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0;
      exp_a = 8'h0; exp_b = 8'h0; man_a = 23'h0; man_b = 23'h0;
      #3;
      total++;
      if ({ldt, shr, busy, done, swap, sticky, shift_cnt, inp_temp, man_big, exp_res} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b cnt=%0d exp_res=%h, required all 0",
                  busy, done, shift_cnt, exp_res);
      end
      #4 reset = 1'b0;
      clk_en = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b, required 0", busy); end
   endtask

   task automatic test_basic;
      int nl, ns, lc, dc; logic [4:0] cl; logic b, s;
      run_op(8'h85, 8'h82, 23'h123456, 23'h2AAAAA, nl, ns, lc, dc, cl, b, s);
      total++;
      if (swap !== 1'b0 || exp_res !== 8'h85) begin
         bad++; $display("FAIL basic_sel: swap=%b exp_res=%h, required 0/85", swap, exp_res);
      end
      total++;
      if (inp_temp !== 23'h2AAAAA || man_big !== 23'h123456) begin
         bad++; $display("FAIL basic_man: inp_temp=%h man_big=%h, required 2aaaaa/123456", inp_temp, man_big);
      end
      total++;
      if (nl !== 1 || lc !== 1 || ns !== 3 || cl !== 5'd3 || b !== 1'b0) begin
         bad++; $display("FAIL basic_strobes: ldt=%0d@%0d shr=%0d cnt=%0d overlap=%b, required 1@1 3 3 0",
                         nl, lc, ns, cl, b);
      end
      total++;
      if (dc !== 5) begin bad++; $display("FAIL basic_done_cycle: got %0d, required 5", dc); end
      total++;
      if (temp !== 24'h155555) begin bad++; $display("FAIL basic_temp: got %h, required 155555", temp); end
      // A has the smaller exponent: A is shifted once
      run_op(8'h80, 8'h81, 23'h000001, 23'h7FFFFF, nl, ns, lc, dc, cl, b, s);
      total++;
      if (swap !== 1'b1 || exp_res !== 8'h81 || inp_temp !== 23'h000001 || man_big !== 23'h7FFFFF) begin
         bad++; $display("FAIL swap_sel: swap=%b exp_res=%h inp=%h big=%h, required 1/81/000001/7fffff",
                         swap, exp_res, inp_temp, man_big);
      end
      total++;
      if (ns !== 1 || dc !== 3 || temp !== 24'h400000) begin
         bad++; $display("FAIL swap_shift: shr=%0d done@%0d temp=%h, required 1/3/400000", ns, dc, temp);
      end
   endtask

   task automatic test_equal;
      int nl, ns, lc, dc; logic [4:0] cl; logic b, s;
      run_op(8'h7F, 8'h7F, 23'h111111, 23'h222222, nl, ns, lc, dc, cl, b, s);
      total++;
      if (swap !== 1'b0 || inp_temp !== 23'h222222 || exp_res !== 8'h7F) begin
         bad++; $display("FAIL equal_sel: swap=%b inp=%h exp_res=%h, required 0/222222/7f", swap, inp_temp, exp_res);
      end
      total++;
      if (nl !== 1 || ns !== 0 || dc !== 2) begin
         bad++; $display("FAIL equal_timing: ldt=%0d shr=%0d done@%0d, required 1/0/2", nl, ns, dc);
      end
   endtask

   task automatic test_saturation;
      int nl, ns, lc, dc; logic [4:0] cl; logic b, s;
      run_op(8'h10, 8'hF0, 23'h7FFFFF, 23'h0, nl, ns, lc, dc, cl, b, s);
      total++;
      if (swap !== 1'b1 || cl !== 5'd24 || ns !== 24 || dc !== 26 || temp !== 24'h0) begin
         bad++; $display("FAIL sat_224: swap=%b cnt=%0d shr=%0d done@%0d temp=%h, required 1/24/24/26/0",
                         swap, cl, ns, dc, temp);
      end
      // gap of 32 would wrap to 0 in 5 bits without saturation
      run_op(8'hA0, 8'h80, 23'h0, 23'h7FFFFF, nl, ns, lc, dc, cl, b, s);
      total++;
      if (cl !== 5'd24 || ns !== 24 || dc !== 26) begin
         bad++; $display("FAIL sat_32: cnt=%0d shr=%0d done@%0d, required 24/24/26", cl, ns, dc);
      end
      run_op(8'h97, 8'h80, 23'h0, 23'h7FFFFF, nl, ns, lc, dc, cl, b, s);
      total++;
      if (cl !== 5'd23 || ns !== 23 || dc !== 25 || temp !== 24'h000001) begin
         bad++; $display("FAIL gap_23: cnt=%0d shr=%0d done@%0d temp=%h, required 23/23/25/000001",
                         cl, ns, dc, temp);
      end
   endtask

   task automatic test_busy_start;
      int ns, dc;
      ns = 0; dc = 0;
      @(negedge clk);
      exp_a = 8'h85; exp_b = 8'h80; man_a = 23'h0; man_b = 23'h7FFFFF; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         if (c == 3) begin start = 1'b1; exp_a = 8'h01; exp_b = 8'h90; end
         if (c == 4) start = 1'b0;
         if (shr) ns++;
         if (done) begin dc = c; break; end
      end
      total++;
      if (ns !== 5 || dc !== 7 || exp_res !== 8'h85 || swap !== 1'b0) begin
         bad++; $display("FAIL busy_start: shr=%0d done@%0d exp_res=%h swap=%b, required 5/7/85/0",
                         ns, dc, exp_res, swap);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_norestart: busy=%b, required 0", busy); end
   endtask

   task automatic test_reset_mid;
      int nl, ns, lc, dc; logic [4:0] cl; logic b, s;
      @(negedge clk);
      exp_a = 8'h98; exp_b = 8'h80; man_a = 23'h5; man_b = 23'h6; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (shr !== 1'b1) begin bad++; $display("FAIL mid_in_shift: shr=%b, required 1", shr); end
      reset = 1'b1;
      #1;
      total++;
      if ({ldt, shr, busy, done, swap, sticky, shift_cnt, inp_temp, man_big, exp_res} !== '0) begin
         bad++; $display("FAIL mid_reset: busy=%b shr=%b cnt=%0d exp_res=%h, required all 0",
                         busy, shr, shift_cnt, exp_res);
      end
      #2 reset = 1'b0;
      run_op(8'h85, 8'h82, 23'h0, 23'h2AAAAA, nl, ns, lc, dc, cl, b, s);
      total++;
      if (ns !== 3 || dc !== 5 || temp !== 24'h155555) begin
         bad++; $display("FAIL after_reset: shr=%0d done@%0d temp=%h, required 3/5/155555", ns, dc, temp);
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] got;
      @(negedge clk);
      exp_a = 8'h40; exp_b = 8'h40; start = 1'b1;
      @(posedge clk);
      got = 4'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         case (c)
            1: got[0] = ldt;
            2: got[1] = done;
            3: got[2] = ~busy;
            default: got[3] = ldt;
         endcase
      end
      start = 1'b0;
      total++;
      if (got !== 4'b1111) begin
         bad++; $display("FAIL back_to_back: seq=%b, required 1111 (ldt,done,idle,ldt)", got);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_sticky;
      int nl, ns, lc, dc; logic [4:0] cl; logic b, s;
      logic exp_hit;
`ifdef FP32_ALIGN_STICKY_EN
      exp_hit = 1'b1;
`else
      exp_hit = 1'b0;
`endif
      run_op(8'h82, 8'h80, 23'h0, 23'h000004, nl, ns, lc, dc, cl, b, s);
      total++;
      if (s !== 1'b0) begin bad++; $display("FAIL sticky_zero: got %b, required 0", s); end
      run_op(8'h82, 8'h80, 23'h0, 23'h000003, nl, ns, lc, dc, cl, b, s);
      total++;
      if (s !== exp_hit) begin bad++; $display("FAIL sticky_three: got %b, required %b", s, exp_hit); end
      run_op(8'h82, 8'h80, 23'h0, 23'h000002, nl, ns, lc, dc, cl, b, s);
      total++;
      if (s !== exp_hit) begin bad++; $display("FAIL sticky_bit1: got %b, required %b", s, exp_hit); end
      run_op(8'h82, 8'h80, 23'h0, 23'h000004, nl, ns, lc, dc, cl, b, s);
      total++;
      if (s !== 1'b0) begin bad++; $display("FAIL sticky_clear: got %b, required 0", s); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_equal();
      test_saturation();
      test_busy_start();
      test_reset_mid();
      test_back_to_back();
      test_sticky();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
